pipeline_hazard_unit: RTL

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/pipeline_hazard_unit_pkg.sv | 26 ++
 rtl/pipeline_hazard_unit_if.sv | 58 +++++
 rtl/pipeline_hazard_unit_raw_detect.sv | 50 +++++
 rtl/pipeline_hazard_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: FSM state encoding and
// bit positions of the decode instruction-class vector.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } pipe_state_e;

  // Instruction-class vector layout {store, load, jump, branch}
  localparam int CLS_W      = 4;
  localparam int CLS_BRANCH = 0;
  localparam int CLS_JUMP   = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;

  typedef logic [CLS_W-1:0] cls_t;

  // A penalty of N flush cycles loads the down-counter with N-1
  function automatic logic [2:0] penalty_load(input int penalty);
    return 3'(penalty - 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
// Handshake: the hazard unit has no valid/ready pair; every enable is a
// same-cycle combinational qualifier on the datapath stage it names, and a
// stage only advances in a cycle where its enable is 1.
interface pipe_hazard_if
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSTAGE = 2
);

  logic                     dec_valid;
  logic [REG_AW-1:0]        dec_rs1;
  logic [REG_AW-1:0]        dec_rs2;
  logic                     dec_use_rs1;
  logic                     dec_use_rs2;
  logic                     dec_is_branch;
  logic                     dec_is_jump;
  logic                     dec_is_load;
  logic                     dec_is_store;
  logic [NSTAGE*REG_AW-1:0] stage_rd;
  logic [NSTAGE-1:0]        stage_wr;
  logic [NSTAGE-1:0]        stage_is_load;
  logic                     br_resolve;
  logic                     br_taken;
  logic                     mem_busy;
  logic                     store_ack;

  logic                     en_fetch;
  logic                     en_decode;
  logic                     en_exec;
  logic                     en_mem;
  logic                     en_regs;
  logic                     bubble_ex;
  logic                     flush_fe;
  logic                     flush_de;
  logic [2:0]               stq_count;
  pipe_state_e              state_dbg;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_is_branch, dec_is_jump, dec_is_load, dec_is_store,
           stage_rd, stage_wr, stage_is_load,
           br_resolve, br_taken, mem_busy, store_ack,
    input  en_fetch, en_decode, en_exec, en_mem, en_regs,
           bubble_ex, flush_fe, flush_de, stq_count, state_dbg
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_is_branch, dec_is_jump, dec_is_load, dec_is_store,
           stage_rd, stage_wr, stage_is_load,
           br_resolve, br_taken, mem_busy, store_ack,
    output en_fetch, en_decode, en_exec, en_mem, en_regs,
           bubble_ex, flush_fe, flush_de, stq_count, state_dbg
  );

endinterface

// File: rtl/pipeline_hazard_unit_raw_detect.sv
// Combinational read-after-write detector between the decode sources and
// the destination registers of the downstream stages. With forwarding only
// a load sitting in the nearest stage can still cause a hazard.
module raw_detect #(
  parameter int REG_AW = 5,
  parameter int NSTAGE = 2,
  parameter int FWD_EN = 0
) (
  input  logic                     i_dec_valid,
  input  logic [REG_AW-1:0]        i_rs1,
  input  logic [REG_AW-1:0]        i_rs2,
  input  logic                     i_use_rs1,
  input  logic                     i_use_rs2,
  input  logic [NSTAGE*REG_AW-1:0] i_stage_rd,
  input  logic [NSTAGE-1:0]        i_stage_wr,
  input  logic [NSTAGE-1:0]        i_stage_is_load,
  output logic                     o_raw
);

  logic [NSTAGE-1:0] w_stage_hit;
  logic              w_unused_load;

  // Only stage 0's load flag matters, and only with forwarding enabled
  assign w_unused_load = ^i_stage_is_load;

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    logic [REG_AW-1:0] w_rd;
    logic              w_match;
    logic              w_checked;

    assign w_rd    = i_stage_rd[g*REG_AW +: REG_AW];
    // Register 0 is hard-wired and never creates a dependency
    assign w_match = i_stage_wr[g] && (w_rd != '0) &&
                     (((w_rd == i_rs1) && i_use_rs1) ||
                      ((w_rd == i_rs2) && i_use_rs2));

    if (FWD_EN == 0) begin : g_nofwd
      assign w_checked = 1'b1;
    end else if (g == 0) begin : g_fwd_near
      assign w_checked = i_stage_is_load[0];
    end else begin : g_fwd_far
      assign w_checked = 1'b0;
    end

    assign w_stage_hit[g] = w_match && w_checked;
  end

  assign o_raw = i_dec_valid && (|w_stage_hit);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: stalls decode on RAW and store-queue hazards,
// flushes fetch/decode after jumps and taken branches, parks the pipe while
// a load completes and freezes everything while data memory is busy.
module pipeline_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int NSTAGE      = 2,
  parameter int BR_PENALTY  = 2,
  parameter int JMP_PENALTY = 2,
  parameter int STQ_DEPTH   = 2,
  parameter int FWD_EN      = 0
) (
  input logic        clk,
  input logic        rst,
  pipe_hazard_if.slave bus
);

  localparam logic [2:0] BR_LOAD  = penalty_load(BR_PENALTY);
  localparam logic [2:0] JMP_LOAD = penalty_load(JMP_PENALTY);
  localparam logic [2:0] STQ_MAX  = 3'(STQ_DEPTH);

  pipe_state_e r_state;
  pipe_state_e w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic [2:0]  r_stq_count;

  cls_t w_cls;
  logic w_unused_cls;
  logic w_raw;
  logic w_store_stall;
  logic w_load_stall;
  logic w_stall;
  logic w_live;
  logic w_br_flush;
  logic w_accept;
  logic w_stq_inc;
  logic w_stq_dec;

  logic w_en_fetch;
  logic w_en_decode;
  logic w_en_exec;
  logic w_en_mem;
  logic w_en_regs;
  logic w_bubble_ex;
  logic w_flush_fe;
  logic w_flush_de;

  assign w_cls[CLS_BRANCH] = bus.dec_is_branch;
  assign w_cls[CLS_JUMP]   = bus.dec_is_jump;
  assign w_cls[CLS_LOAD]   = bus.dec_is_load;
  assign w_cls[CLS_STORE]  = bus.dec_is_store;
  // A branch in decode needs no special handling until it resolves
  assign w_unused_cls      = w_cls[CLS_BRANCH];

  raw_detect #(
    .REG_AW (REG_AW),
    .NSTAGE (NSTAGE),
    .FWD_EN (FWD_EN)
  ) u_raw_detect (
    .i_dec_valid     (bus.dec_valid),
    .i_rs1           (bus.dec_rs1),
    .i_rs2           (bus.dec_rs2),
    .i_use_rs1       (bus.dec_use_rs1),
    .i_use_rs2       (bus.dec_use_rs2),
    .i_stage_rd      (bus.stage_rd),
    .i_stage_wr      (bus.stage_wr),
    .i_stage_is_load (bus.stage_is_load),
    .o_raw           (w_raw)
  );

  // A store may still enter a full queue if one retires in the same cycle;
  // loads wait until every older store has retired.
  assign w_store_stall = bus.dec_valid && w_cls[CLS_STORE] &&
                         (r_stq_count == STQ_MAX) && !bus.store_ack;
  assign w_load_stall  = bus.dec_valid && w_cls[CLS_LOAD] &&
                         (r_stq_count != 3'd0);
  assign w_stall       = w_raw || w_store_stall || w_load_stall;

  // Cycles in which the pipe is actually moving. The first non-busy cycle
  // of MEM_WAIT resumes the pipe, so it is evaluated exactly like RUN.
  assign w_live     = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) &&
                      !bus.mem_busy;
  // A taken branch wins over stalls and over whatever sits in decode
  assign w_br_flush = w_live && bus.br_resolve && bus.br_taken;
  assign w_accept   = w_live && !w_br_flush && bus.dec_valid && !w_stall;

  assign w_stq_inc  = w_accept && w_cls[CLS_STORE];
  assign w_stq_dec  = bus.store_ack && (r_stq_count != 3'd0);

  // FSM state and flush counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and stage-enable decode
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_en_fetch   = 1'b0;
    w_en_decode  = 1'b0;
    w_en_exec    = 1'b0;
    w_en_mem     = 1'b0;
    w_en_regs    = 1'b0;
    w_bubble_ex  = 1'b0;
    w_flush_fe   = 1'b0;
    w_flush_de   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_state_next = ST_RUN;
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (bus.mem_busy) begin
          // Frozen; only the memory stage keeps the pending load presented
          w_en_mem = (r_state == ST_MEM_WAIT);
        end else if (w_br_flush) begin
          // Hold the wrong-path fetch/decode and bubble execute
          w_en_exec    = 1'b1;
          w_en_mem     = 1'b1;
          w_en_regs    = 1'b1;
          w_bubble_ex  = 1'b1;
          w_state_next = ST_FLUSH;
          w_cnt_next   = BR_LOAD;
        end else if (w_stall) begin
          w_en_exec    = 1'b1;
          w_en_mem     = 1'b1;
          w_en_regs    = 1'b1;
          w_bubble_ex  = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_en_fetch   = 1'b1;
          w_en_decode  = 1'b1;
          w_en_exec    = 1'b1;
          w_en_mem     = 1'b1;
          w_en_regs    = 1'b1;
          w_state_next = ST_RUN;
          if (w_accept && w_cls[CLS_JUMP]) begin
            w_state_next = ST_FLUSH;
            w_cnt_next   = JMP_LOAD;
          end else if (w_accept && w_cls[CLS_LOAD]) begin
            w_state_next = ST_MEM_WAIT;
          end
        end
      end

      ST_FLUSH: begin
        w_flush_fe  = 1'b1;
        w_flush_de  = 1'b1;
        w_bubble_ex = 1'b1;
        if (!bus.mem_busy) begin
          w_en_fetch  = 1'b1;
          w_en_decode = 1'b1;
          w_en_exec   = 1'b1;
          w_en_mem    = 1'b1;
          w_en_regs   = 1'b1;
          if (r_cnt == 3'd0) begin
            w_state_next = ST_RUN;
          end else begin
            w_cnt_next = r_cnt - 3'd1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 3'd0;
      end
    endcase
  end

  // Outstanding store counter; the stall logic keeps it within STQ_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stq_count <= 3'd0;
    end else begin
      unique case ({w_stq_inc, w_stq_dec})
        2'b10:   r_stq_count <= r_stq_count + 3'd1;
        2'b01:   r_stq_count <= r_stq_count - 3'd1;
        default: r_stq_count <= r_stq_count;
      endcase
    end
  end

  assign bus.en_fetch  = w_en_fetch;
  assign bus.en_decode = w_en_decode;
  assign bus.en_exec   = w_en_exec;
  assign bus.en_mem    = w_en_mem;
  assign bus.en_regs   = w_en_regs;
  assign bus.bubble_ex = w_bubble_ex;
  assign bus.flush_fe  = w_flush_fe;
  assign bus.flush_de  = w_flush_de;
  assign bus.stq_count = r_stq_count;
  assign bus.state_dbg = r_state;

endmodule
